// File: rtl/keyboard_matrix.sv
// keyboard_matrix: Wishbone-writable 10 x 8 PET keyboard matrix.
//
// The host MCU loads the key state (active-low columns) through Wishbone.
// CPU writes to PIA1 are snooped to follow the keyboard row select on
// PORTA[3:0], and the column byte for that row is presented to the PIA1
// PORTB read path.
//
// Ports:
//   clock_i, reset_n_i      system clock, asynchronous active-low reset
//   wb_addr_i/wb_data_i/wb_we_i/wb_cyc_i/wb_stb_i   Wishbone request
//   wb_data_o/wb_ack_o/wb_stall_o                    Wishbone response
//   cpu_data_strobe_i/cpu_we_i/pia1_cs_i/pia_rs_i/cpu_data_i  CPU bus snoop
//   kbd_row_o               current row select
//   kbd_col_o               registered column byte for the selected row
module keyboard_matrix #(
  parameter int unsigned ROW_COUNT    = 10,
  parameter int unsigned ADDR_WIDTH   = 4,
  parameter logic [7:0]  IDLE_VALUE   = 8'hFF,
  parameter int unsigned PIA_RS_WIDTH = 2,
  parameter logic [PIA_RS_WIDTH-1:0] PIA_PORTA = PIA_RS_WIDTH'(0),
  parameter logic [PIA_RS_WIDTH-1:0] PIA_CRA   = PIA_RS_WIDTH'(1)
) (
  input  logic                    clock_i,
  input  logic                    reset_n_i,
  input  logic [ADDR_WIDTH-1:0]   wb_addr_i,
  input  logic [7:0]              wb_data_i,
  output logic [7:0]              wb_data_o,
  input  logic                    wb_we_i,
  input  logic                    wb_cyc_i,
  input  logic                    wb_stb_i,
  output logic                    wb_ack_o,
  output logic                    wb_stall_o,
  input  logic                    cpu_data_strobe_i,
  input  logic                    cpu_we_i,
  input  logic                    pia1_cs_i,
  input  logic [PIA_RS_WIDTH-1:0] pia_rs_i,
  input  logic [7:0]              cpu_data_i,
  output logic [3:0]              kbd_row_o,
  output logic [7:0]              kbd_col_o
);

  logic [7:0] matrix_q [ROW_COUNT];
  logic [3:0] row_sel_q;
  logic       cra_ddr_n_q;
  logic       ack_q;
  logic [7:0] rdata_q;
  logic [7:0] col_q;

  logic       wb_req;
  logic       snoop_wr;
  logic [7:0] wb_rd_data;
  logic [7:0] col_data;

  // Only CRA[2] and PORTA[3:0] matter to the keyboard.
  logic unused_cpu_bits;
  assign unused_cpu_bits = ^{cpu_data_i[7:4], cpu_data_i[1:0]};

  assign wb_req   = wb_cyc_i & wb_stb_i;
  assign snoop_wr = cpu_data_strobe_i & pia1_cs_i & cpu_we_i;

  // Out-of-range rows fall through to the idle value.
  always_comb begin
    wb_rd_data = IDLE_VALUE;
    col_data   = IDLE_VALUE;
    for (int i = 0; i < int'(ROW_COUNT); i++) begin
      if (wb_addr_i == ADDR_WIDTH'(i)) wb_rd_data = matrix_q[i];
      if (row_sel_q == 4'(i))          col_data   = matrix_q[i];
    end
  end

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int i = 0; i < int'(ROW_COUNT); i++) matrix_q[i] <= IDLE_VALUE;
    end else if (wb_req && wb_we_i) begin
      for (int i = 0; i < int'(ROW_COUNT); i++) begin
        if (wb_addr_i == ADDR_WIDTH'(i)) matrix_q[i] <= wb_data_i;
      end
    end
  end

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      ack_q   <= 1'b0;
      rdata_q <= 8'h00;
    end else begin
      ack_q <= wb_req;
      if (wb_req && !wb_we_i) rdata_q <= wb_rd_data;
    end
  end

  // With CRA[2] clear, PORTA writes go to the data direction register.
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      cra_ddr_n_q <= 1'b0;
      row_sel_q   <= 4'd0;
    end else if (snoop_wr) begin
      if (pia_rs_i == PIA_CRA) cra_ddr_n_q <= cpu_data_i[2];
      if (pia_rs_i == PIA_PORTA && cra_ddr_n_q) row_sel_q <= cpu_data_i[3:0];
    end
  end

  // Sampled from current state, so matrix/row changes land one edge later.
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) col_q <= IDLE_VALUE;
    else            col_q <= col_data;
  end

  assign wb_data_o  = rdata_q;
  assign wb_ack_o   = ack_q;
  assign wb_stall_o = 1'b0;
  assign kbd_row_o  = row_sel_q;
  assign kbd_col_o  = col_q;

endmodule

// File: tb/tb_keyboard_matrix.sv
module tb_keyboard_matrix;

  localparam logic [1:0] RS_PORTA = 2'd0;
  localparam logic [1:0] RS_CRA   = 2'd1;
  localparam logic [1:0] RS_PORTB = 2'd2;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] wb_addr;
  logic [7:0] wb_wdata;
  logic [7:0] wb_rdata;
  logic       wb_we, wb_cyc, wb_stb, wb_ack, wb_stall;
  logic       cpu_strobe, cpu_we, pia1_cs;
  logic [1:0] pia_rs;
  logic [7:0] cpu_data;
  logic [3:0] kbd_row;
  logic [7:0] kbd_col;

  typedef struct packed {
    logic       rd;
    logic [7:0] d;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] exp_mat [10];
  int         n_vec = 0;
  int         n_bad = 0;

  keyboard_matrix dut (
    .clock_i           (clk),
    .reset_n_i         (reset_n),
    .wb_addr_i         (wb_addr),
    .wb_data_i         (wb_wdata),
    .wb_data_o         (wb_rdata),
    .wb_we_i           (wb_we),
    .wb_cyc_i          (wb_cyc),
    .wb_stb_i          (wb_stb),
    .wb_ack_o          (wb_ack),
    .wb_stall_o        (wb_stall),
    .cpu_data_strobe_i (cpu_strobe),
    .cpu_we_i          (cpu_we),
    .pia1_cs_i         (pia1_cs),
    .pia_rs_i          (pia_rs),
    .cpu_data_i        (cpu_data),
    .kbd_row_o         (kbd_row),
    .kbd_col_o         (kbd_col)
  );

  always #5 clk = ~clk;

  // Monitor: every ack must match the oldest outstanding request.
  always @(negedge clk) begin
    if (wb_ack) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL wb_ack_unexpected: got ack with no request outstanding");
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (e.rd && wb_rdata !== e.d) begin
          n_bad++;
          $display("FAIL wb_read_data: got %h expected %h", wb_rdata, e.d);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Presents one request for one cycle; caller decides whether it is expected.
  task automatic wb_issue(input logic we, input logic [3:0] a, input logic [7:0] d,
                          input bit push);
    @(posedge clk); #1;
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we; wb_addr = a; wb_wdata = d;
    if (push) begin
      exp_q.push_back('{rd: !we, d: (a < 4'd10) ? exp_mat[a] : 8'hFF});
      if (we && a < 4'd10) exp_mat[a] = d;
    end
  endtask

  task automatic wb_idle();
    @(posedge clk); #1;
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
  endtask

  task automatic cpu_write(input logic [1:0] rs, input logic [7:0] d);
    @(posedge clk); #1;
    cpu_strobe = 1'b1; pia1_cs = 1'b1; cpu_we = 1'b1; pia_rs = rs; cpu_data = d;
    @(posedge clk); #1;
    cpu_strobe = 1'b0; pia1_cs = 1'b0; cpu_we = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0;
    wb_addr = '0; wb_wdata = '0; wb_we = 0; wb_cyc = 0; wb_stb = 0;
    cpu_strobe = 0; cpu_we = 0; pia1_cs = 0; pia_rs = '0; cpu_data = '0;
    for (int i = 0; i < 10; i++) exp_mat[i] = 8'hFF;

    repeat (2) @(posedge clk);
    #1;
    chk("reset_ack", {7'd0, wb_ack}, 8'h00);
    chk("reset_rdata", wb_rdata, 8'h00);
    chk("reset_col", kbd_col, 8'hFF);
    chk("reset_row", {4'd0, kbd_row}, 8'h00);
    chk("stall", {7'd0, wb_stall}, 8'h00);
    reset_n = 1'b1;

    for (int i = 0; i < 10; i++) wb_issue(1'b0, 4'(i), 8'h00, 1'b1);
    wb_idle();

    // Row select via PORTA once CRA[2] is set.
    wb_issue(1'b1, 4'd3, 8'hFE, 1'b1);
    wb_idle();
    cpu_write(RS_CRA, 8'h04);
    cpu_write(RS_PORTA, 8'h03);
    chk("row_after_porta", {4'd0, kbd_row}, 8'h03);
    chk("col_latency", kbd_col, 8'hFF);
    @(posedge clk); #1;
    chk("col_row3", kbd_col, 8'hFE);

    // DDR access leaves the row alone.
    cpu_write(RS_CRA, 8'h00);
    cpu_write(RS_PORTA, 8'h05);
    @(posedge clk); #1;
    chk("ddr_row_kept", {4'd0, kbd_row}, 8'h03);
    chk("ddr_col_kept", kbd_col, 8'hFE);

    // Out-of-range Wishbone rows, and stb without cyc.
    wb_issue(1'b1, 4'd12, 8'h00, 1'b1);
    wb_issue(1'b0, 4'd12, 8'h00, 1'b1);
    wb_idle();
    @(posedge clk); #1;
    wb_stb = 1'b1; wb_we = 1'b1; wb_addr = 4'd0; wb_wdata = 8'h00;
    @(posedge clk); #1;
    wb_stb = 1'b0; wb_we = 1'b0;
    wb_issue(1'b0, 4'd0, 8'h00, 1'b1);
    wb_idle();

    cpu_write(RS_CRA, 8'h04);
    cpu_write(RS_PORTA, 8'h0B);
    @(posedge clk); #1;
    chk("row_oob", {4'd0, kbd_row}, 8'h0B);
    chk("col_oob", kbd_col, 8'hFF);

    // PORTB writes and CPU reads are not snooped.
    cpu_write(RS_PORTB, 8'h01);
    @(posedge clk); #1;
    cpu_strobe = 1'b1; pia1_cs = 1'b1; cpu_we = 1'b0; pia_rs = RS_PORTA; cpu_data = 8'h02;
    @(posedge clk); #1;
    cpu_strobe = 1'b0; pia1_cs = 1'b0;
    chk("ignored_snoops", {4'd0, kbd_row}, 8'h0B);

    // Same-cycle matrix write and row select.
    wb_issue(1'b1, 4'd7, 8'h7F, 1'b1);
    cpu_strobe = 1'b1; pia1_cs = 1'b1; cpu_we = 1'b1; pia_rs = RS_PORTA; cpu_data = 8'h07;
    wb_idle();
    cpu_strobe = 1'b0; pia1_cs = 1'b0; cpu_we = 1'b0;
    chk("simul_row", {4'd0, kbd_row}, 8'h07);
    @(posedge clk); #1;
    chk("simul_col", kbd_col, 8'h7F);

    for (int i = 0; i < 10; i++) wb_issue(1'b0, 4'(i), 8'h00, 1'b1);
    wb_idle();
    repeat (2) @(posedge clk);

    // Reset during a pending ack drops it.
    wb_issue(1'b0, 4'd3, 8'h00, 1'b0);
    @(posedge clk); #1;
    reset_n = 1'b0;
    wb_cyc = 1'b0; wb_stb = 1'b0;
    #1;
    chk("reset_drops_ack", {7'd0, wb_ack}, 8'h00);
    chk("reset_col_async", kbd_col, 8'hFF);
    chk("reset_row_async", {4'd0, kbd_row}, 8'h00);
    for (int i = 0; i < 10; i++) exp_mat[i] = 8'hFF;
    repeat (2) @(posedge clk);
    #3;
    reset_n = 1'b1;
    repeat (3) @(posedge clk);
    wb_issue(1'b0, 4'd3, 8'h00, 1'b1);
    wb_issue(1'b0, 4'd7, 8'h00, 1'b1);
    wb_idle();
    repeat (3) @(posedge clk);
    #1;
    chk("acks_outstanding", 8'(exp_q.size()), 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
